object_bus_master: RTL and testbench
====================================

// Module: object_bus_master
// PURPOSE
//  Initiator for the shared object-cell bus: turns upstream ALLOC/FREE/MAP/TRANSLATE requests into
//  single-cycle cell command strobes. It returns allocated handles, translated addresses and error status.
//  Sits between the load/store front end and the array of NUM_CELLS handle cells, ahead of virtual address translation.
//  After reset it sweeps all cells invalid, so no handle is valid until a later ALLOC.
// PARAMETERS
//  ADDR_WIDTH  64  full address width
//  HNDL_WIDTH  15  handle width
//  NUM_CELLS   32  cells present; valid handles are 0..NUM_CELLS-1
//  DW          ADDR_WIDTH-HNDL_WIDTH-1 (localparam, 48)  cell data / mapped-address width
// PORTS
//  clock                  in   1     single clock; all state on posedge
//  reset_n                in   1     asynchronous, active-low reset
//  req_valid              in   1     request present
//  req_ready              out  1     request accepted when valid&ready at posedge
//  req_op                 in   2     00 ALLOC, 01 FREE, 10 MAP, 11 TRANSLATE
//  req_handle             in   HW    target handle (ignored for ALLOC)
//  req_data               in   DW    MAP: base address; TRANSLATE: offset
//  resp_valid             out  1     response present; held until resp_ready
//  resp_ready             in   1     response consumed when valid&ready at posedge
//  resp_handle            out  HW    ALLOC: new handle; otherwise echoes req_handle
//  resp_data              out  DW    TRANSLATE: base+offset; otherwise 0
//  resp_error             out  1     out-of-range handle, no free cell, or add carry
//  cell_cs                out  HW    cell select
//  cell_data_out          out  DW    value driven onto the triand data bus
//  cell_data_oe           out  1     drive enable for cell_data_out (the top level resolves the tristate)
//  cell_data_in           in   DW    resolved bus value
//  cell_write_to_map      out  1     strobe: selected cell latches the bus as its base
//  cell_get_available_id  out  1     strobe: the lowest invalid cell drives its id and becomes valid
//  cell_write_invalid     out  1     strobe: selected cell becomes invalid
//  cell_read_address      out  1     strobe: selected cell drives its base
// BEHAVIOUR
//  Reset values
//  - Every output is 0. FSM enters INIT and the sweep counter is 0.
//  - Reset asserted mid-operation aborts the operation: a pending response is lost and INIT restarts.
//  FSM states
//  - INIT, IDLE, ISSUE, RESP.
//  INIT
//  - Lasts NUM_CELLS cycles. In each cycle cell_cs = counter and cell_write_invalid = 1; the counter then increments.
//  - Goes to IDLE after cs = NUM_CELLS-1. req_ready = 0 throughout.
//  IDLE
//  - req_ready = 1 and all strobes are 0.
//  - On accept, the request is registered.
//  - FREE/MAP/TRANSLATE with req_handle >= NUM_CELLS goes straight to RESP with error=1 and issues no bus cycle.
//  - Every other request goes to ISSUE.
//  ISSUE (exactly one cycle)
//  - Drives exactly one strobe. cell_cs = registered handle (0 for ALLOC).
//  - Cells commit on negedge inside this cycle.
//  - MAP: oe=1, cell_data_out = req_data, write_to_map=1.
//  - FREE: write_invalid=1, oe=0.
//  - TRANSLATE: read_address=1, oe=0.
//  - ALLOC: get_available_id=1, oe=0.
//  - At the posedge ending ISSUE, cell_data_in is sampled and the FSM goes to RESP.
//  ALLOC result
//  - Handle = cell_data_in[HW-1:0].
//  - If handle >= NUM_CELLS (bus idles all-ones: no free cell), error=1 and resp_handle = that value.
//  TRANSLATE result
//  - resp_data = cell_data_in + req_data, modulo 2^DW.
//  - error=1 on carry out.
//  RESP
//  - resp_valid = 1 with stable fields. On resp_ready, go to IDLE; req_ready stays 0 until then.
//  Timing
//  - Latency from the accept edge: resp_valid asserts 2 cycles later via ISSUE, 1 cycle later on a range error.
//  - Throughput: one outstanding request. Back-to-back best case is one request per 3 cycles.
//  - Outside ISSUE/INIT, all strobes and oe are 0 and cell_cs holds its last value.
// TESTING
//  - Reset release -> 32 cycles with write_invalid=1 and cs=0..31, then req_ready=1. Next ALLOC -> handle 0, error 0.
//  - ALLOC x3 -> handles 0,1,2. FREE 1, then ALLOC -> handle 1. resp_valid is 2 cycles after each accept.
//  - MAP h=2 base=0x0000_1000_0000, then TRANSLATE h=2 off=0x10 -> resp_data 0x0000_1000_0010, error 0.
//  - TRANSLATE with base 0xFFFF_FFFF_FFF0, off 0x20 -> resp_data 0x10, error 1.
//  - FREE h=40 -> error 1 one cycle after accept, no strobe. 33rd ALLOC with all cells valid -> error 1.
//  - resp_ready held 0 for 5 cycles -> response stable and req_ready 0. reset_n pulsed in ISSUE -> outputs 0, INIT restarts.

Source files
------------

// File: rtl/object_bus_master.sv
// object_bus_master
// Initiator for the shared object-cell bus. Converts upstream ALLOC/FREE/MAP/
// TRANSLATE requests into single-cycle cell command strobes. It returns the
// allocated handle, the translated address and an error flag. After reset it
// sweeps every cell invalid before it accepts the first request.
module object_bus_master #(
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 15,
    parameter int NUM_CELLS  = 32,
    localparam int DW        = ADDR_WIDTH - HNDL_WIDTH - 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // upstream request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [HNDL_WIDTH-1:0] req_handle,
    input  logic [DW-1:0]         req_data,
    // upstream response channel
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [HNDL_WIDTH-1:0] resp_handle,
    output logic [DW-1:0]         resp_data,
    output logic                  resp_error,
    // cell bus
    output logic [HNDL_WIDTH-1:0] cell_cs,
    output logic [DW-1:0]         cell_data_out,
    output logic                  cell_data_oe,
    input  logic [DW-1:0]         cell_data_in,
    output logic                  cell_write_to_map,
    output logic                  cell_get_available_id,
    output logic                  cell_write_invalid,
    output logic                  cell_read_address
);

    localparam int HW = HNDL_WIDTH;
    localparam int CW = $clog2(NUM_CELLS + 1);
    localparam logic [HW-1:0] LP_LIMIT     = HW'(NUM_CELLS);
    localparam logic [CW-1:0] LP_SWEEP_END = CW'(NUM_CELLS);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_ALLOC     = 2'b00,
        OP_FREE      = 2'b01,
        OP_MAP       = 2'b10,
        OP_TRANSLATE = 2'b11
    } op_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    op_t           r_op;
    logic [HW-1:0] r_handle;
    logic [DW-1:0] r_data;

    logic          r_req_ready;
    logic          r_resp_valid;
    logic [HW-1:0] r_resp_handle;
    logic [DW-1:0] r_resp_data;
    logic          r_resp_error;
    logic [HW-1:0] r_cell_cs;
    logic [DW-1:0] r_cell_data_out;
    logic          r_cell_data_oe;
    logic          r_cell_write_to_map;
    logic          r_cell_get_available_id;
    logic          r_cell_write_invalid;
    logic          r_cell_read_address;

    op_t           w_req_op;
    logic          w_accept;
    logic          w_req_in_range;
    logic [HW-1:0] w_alloc_handle;
    logic [DW:0]   w_sum;

    assign w_req_op       = op_t'(req_op);
    assign w_accept       = req_valid & r_req_ready;
    assign w_req_in_range = (req_handle < LP_LIMIT);
    assign w_alloc_handle = cell_data_in[HW-1:0];
    // extra MSB catches the carry out of the base+offset add
    assign w_sum          = {1'b0, cell_data_in} + {1'b0, r_data};

    // Sweep, request capture, single-cycle bus command and response hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state                 <= ST_INIT;
            r_cnt                   <= '0;
            r_op                    <= OP_ALLOC;
            r_handle                <= '0;
            r_data                  <= '0;
            r_req_ready             <= 1'b0;
            r_resp_valid            <= 1'b0;
            r_resp_handle           <= '0;
            r_resp_data             <= '0;
            r_resp_error            <= 1'b0;
            r_cell_cs               <= '0;
            r_cell_data_out         <= '0;
            r_cell_data_oe          <= 1'b0;
            r_cell_write_to_map     <= 1'b0;
            r_cell_get_available_id <= 1'b0;
            r_cell_write_invalid    <= 1'b0;
            r_cell_read_address     <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // outputs are registered, so the sweep shows up one cycle
                    // after the counter value; the extra pass releases IDLE
                    if (r_cnt != LP_SWEEP_END) begin
                        r_cell_cs            <= HW'(r_cnt);
                        r_cell_write_invalid <= 1'b1;
                        r_cnt                <= r_cnt + 1'b1;
                    end else begin
                        r_cell_write_invalid <= 1'b0;
                        r_req_ready          <= 1'b1;
                        r_state              <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_req_op;
                        r_handle    <= req_handle;
                        r_data      <= req_data;
                        r_req_ready <= 1'b0;
                        if (w_req_op != OP_ALLOC && !w_req_in_range) begin
                            r_resp_valid  <= 1'b1;
                            r_resp_handle <= req_handle;
                            r_resp_data   <= '0;
                            r_resp_error  <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_cell_cs <= (w_req_op == OP_ALLOC) ? '0 : req_handle;
                            case (w_req_op)
                                OP_ALLOC: r_cell_get_available_id <= 1'b1;
                                OP_FREE:  r_cell_write_invalid    <= 1'b1;
                                OP_MAP: begin
                                    r_cell_write_to_map <= 1'b1;
                                    r_cell_data_oe      <= 1'b1;
                                    r_cell_data_out     <= req_data;
                                end
                                default:  r_cell_read_address     <= 1'b1;
                            endcase
                            r_state <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_cell_data_out         <= '0;
                    r_cell_data_oe          <= 1'b0;
                    r_cell_write_to_map     <= 1'b0;
                    r_cell_get_available_id <= 1'b0;
                    r_cell_write_invalid    <= 1'b0;
                    r_cell_read_address     <= 1'b0;
                    r_resp_valid            <= 1'b1;
                    case (r_op)
                        OP_ALLOC: begin
                            r_resp_handle <= w_alloc_handle;
                            r_resp_data   <= '0;
                            r_resp_error  <= (w_alloc_handle >= LP_LIMIT);
                        end
                        OP_TRANSLATE: begin
                            r_resp_handle <= r_handle;
                            r_resp_data   <= w_sum[DW-1:0];
                            r_resp_error  <= w_sum[DW];
                        end
                        default: begin
                            r_resp_handle <= r_handle;
                            r_resp_data   <= '0;
                            r_resp_error  <= 1'b0;
                        end
                    endcase
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign req_ready             = r_req_ready;
    assign resp_valid            = r_resp_valid;
    assign resp_handle           = r_resp_handle;
    assign resp_data             = r_resp_data;
    assign resp_error            = r_resp_error;
    assign cell_cs               = r_cell_cs;
    assign cell_data_out         = r_cell_data_out;
    assign cell_data_oe          = r_cell_data_oe;
    assign cell_write_to_map     = r_cell_write_to_map;
    assign cell_get_available_id = r_cell_get_available_id;
    assign cell_write_invalid    = r_cell_write_invalid;
    assign cell_read_address     = r_cell_read_address;

endmodule

// File: tb/tb_object_bus_master.sv
// Directed bench for object_bus_master with a behavioural handle-cell array.
module tb_object_bus_master;

    localparam int HW = 15;
    localparam int DW = 48;
    localparam int NC = 32;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [HW-1:0] req_handle;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [HW-1:0] resp_handle;
    logic [DW-1:0] resp_data;
    logic          resp_error;
    logic [HW-1:0] cell_cs;
    logic [DW-1:0] cell_data_out;
    logic          cell_data_oe;
    logic [DW-1:0] cell_data_in;
    logic          cell_write_to_map;
    logic          cell_get_available_id;
    logic          cell_write_invalid;
    logic          cell_read_address;

    int n_checks = 0;
    int n_errors = 0;

    object_bus_master #(
        .ADDR_WIDTH(64),
        .HNDL_WIDTH(HW),
        .NUM_CELLS (NC)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_handle           (req_handle),
        .req_data             (req_data),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_handle          (resp_handle),
        .resp_data            (resp_data),
        .resp_error           (resp_error),
        .cell_cs              (cell_cs),
        .cell_data_out        (cell_data_out),
        .cell_data_oe         (cell_data_oe),
        .cell_data_in         (cell_data_in),
        .cell_write_to_map    (cell_write_to_map),
        .cell_get_available_id(cell_get_available_id),
        .cell_write_invalid   (cell_write_invalid),
        .cell_read_address    (cell_read_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cell array: cells start valid so only the reset sweep makes them free.
    bit            cell_valid [NC];
    logic [DW-1:0] cell_base  [NC];
    logic [DW-1:0] bus_val;
    int            strobe_cnt;

    initial begin
        for (int i = 0; i < NC; i++) begin
            cell_valid[i] = 1'b1;
            cell_base[i]  = '0;
        end
        bus_val    = '1;
        strobe_cnt = 0;
    end

    assign cell_data_in = bus_val;

    // cells commit on the falling edge; an undriven bus floats to all-ones
    always @(negedge clock) begin
        bit found;
        found = 1'b0;
        bus_val <= '1;
        if (cell_write_invalid | cell_write_to_map | cell_get_available_id | cell_read_address)
            strobe_cnt <= strobe_cnt + 1;
        if (cell_write_invalid && cell_cs < NC)
            cell_valid[cell_cs] <= 1'b0;
        if (cell_write_to_map && cell_data_oe && cell_cs < NC)
            cell_base[cell_cs] <= cell_data_out;
        if (cell_get_available_id) begin
            for (int i = 0; i < NC; i++) begin
                if (!found && !cell_valid[i]) begin
                    found = 1'b1;
                    bus_val <= DW'(i);
                    cell_valid[i] <= 1'b1;
                end
            end
        end
        if (cell_read_address && cell_cs < NC)
            bus_val <= cell_base[cell_cs];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; hold = cycles to keep resp_ready low after resp_valid.
    task automatic do_req(input logic [1:0] op, input logic [HW-1:0] h, input logic [DW-1:0] d,
                          input int hold, output logic [HW-1:0] rh, output logic [DW-1:0] rd,
                          output logic re, output int lat, output int nstb);
        int w;
        int s0;
        req_op     = op;
        req_handle = h;
        req_data   = d;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clock); #1; w++;
        end
        chk("accept_wait", 64'(w < 100), 64'd1);
        s0 = strobe_cnt;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clock); #1; lat++;
        end
        rh = resp_handle;
        rd = resp_data;
        re = resp_error;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", 64'(resp_data), 64'(rd));
            chk("hold_handle", 64'(resp_handle), 64'(rh));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        nstb = strobe_cnt - s0;
    endtask

    initial begin
        logic [HW-1:0] rh;
        logic [DW-1:0] rd;
        logic          re;
        int            lat;
        int            nstb;
        int            fails_before;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_handle = '0;
        req_data   = '0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_write_invalid", 64'(cell_write_invalid), 64'd0);
        chk("rst_cs", 64'(cell_cs), 64'd0);
        chk("rst_oe", 64'(cell_data_oe), 64'd0);
        reset_n = 1'b1;

        // reset sweep
        fails_before = n_errors;
        for (int i = 0; i < NC; i++) begin
            @(posedge clock); #1;
            chk("sweep_wi", 64'(cell_write_invalid), 64'd1);
            chk("sweep_cs", 64'(cell_cs), 64'(i));
            chk("sweep_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clock); #1;
        chk("post_sweep_ready", 64'(req_ready), 64'd1);
        chk("post_sweep_wi", 64'(cell_write_invalid), 64'd0);
        chk("post_sweep_cs_hold", 64'(cell_cs), 64'd31);

        // ALLOC x3 -> 0,1,2
        for (int i = 0; i < 3; i++) begin
            do_req(2'b00, 15'd0, '0, 0, rh, rd, re, lat, nstb);
            chk("alloc_handle", 64'(rh), 64'(i));
            chk("alloc_err", 64'(re), 64'd0);
            chk("alloc_lat", 64'(lat), 64'd2);
            chk("alloc_strobes", 64'(nstb), 64'd1);
        end

        // FREE 1, then ALLOC reuses 1
        do_req(2'b01, 15'd1, '0, 0, rh, rd, re, lat, nstb);
        chk("free_handle", 64'(rh), 64'd1);
        chk("free_err", 64'(re), 64'd0);
        chk("free_data", 64'(rd), 64'd0);
        chk("free_lat", 64'(lat), 64'd2);
        do_req(2'b00, 15'd0, '0, 0, rh, rd, re, lat, nstb);
        chk("realloc_handle", 64'(rh), 64'd1);
        chk("realloc_err", 64'(re), 64'd0);

        // MAP then TRANSLATE
        do_req(2'b10, 15'd2, 48'h0000_1000_0000, 0, rh, rd, re, lat, nstb);
        chk("map_err", 64'(re), 64'd0);
        chk("map_handle", 64'(rh), 64'd2);
        do_req(2'b11, 15'd2, 48'h10, 0, rh, rd, re, lat, nstb);
        chk("xlate_data", 64'(rd), 64'h0000_1000_0010);
        chk("xlate_err", 64'(re), 64'd0);
        chk("xlate_lat", 64'(lat), 64'd2);

        // TRANSLATE with carry out
        do_req(2'b10, 15'd1, 48'hFFFF_FFFF_FFF0, 0, rh, rd, re, lat, nstb);
        do_req(2'b11, 15'd1, 48'h20, 0, rh, rd, re, lat, nstb);
        chk("carry_data", 64'(rd), 64'h10);
        chk("carry_err", 64'(re), 64'd1);

        // out-of-range FREE: immediate error, no bus cycle
        do_req(2'b01, 15'd40, '0, 0, rh, rd, re, lat, nstb);
        chk("range_err", 64'(re), 64'd1);
        chk("range_handle", 64'(rh), 64'd40);
        chk("range_lat", 64'(lat), 64'd1);
        chk("range_strobes", 64'(nstb), 64'd0);

        // fill remaining cells 3..31, then the next ALLOC finds none
        for (int i = 3; i < NC; i++) begin
            do_req(2'b00, 15'd0, '0, 0, rh, rd, re, lat, nstb);
            chk("fill_handle", 64'(rh), 64'(i));
        end
        do_req(2'b00, 15'd0, '0, 0, rh, rd, re, lat, nstb);
        chk("full_err", 64'(re), 64'd1);
        chk("full_handle", 64'(rh), 64'h7FFF);

        // response held with resp_ready low for 5 cycles
        do_req(2'b11, 15'd2, 48'h10, 5, rh, rd, re, lat, nstb);
        chk("held_data", 64'(rd), 64'h0000_1000_0010);
        chk("held_err", 64'(re), 64'd0);

        // reset pulsed during ISSUE
        req_op    = 2'b00;
        req_handle = '0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("issue_strobe", 64'(cell_get_available_id), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe", 64'(cell_get_available_id), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_cs", 64'(cell_cs), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < NC; i++) begin
            @(posedge clock); #1;
            chk("resweep_wi", 64'(cell_write_invalid), 64'd1);
            chk("resweep_cs", 64'(cell_cs), 64'(i));
        end
        @(posedge clock); #1;
        chk("resweep_ready", 64'(req_ready), 64'd1);
        do_req(2'b00, 15'd0, '0, 0, rh, rd, re, lat, nstb);
        chk("after_rst_alloc", 64'(rh), 64'd0);
        chk("after_rst_err", 64'(re), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
